// File: rtl/bn_affine_act_if.sv
// Stream and coefficient-port bundle for bn_affine_act.
// The slave modport is the block side; the master modport is the producer/consumer side.
interface bn_affine_act_if #(
  parameter int DATA_WIDTH = 16,
  parameter int size       = 4,
  parameter int CHANNELS   = 32
);
  localparam int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  logic                         in_valid;
  logic                         in_ready;
  logic [DATA_WIDTH*size-1:0]   in_data;
  logic                         frame_start;
  logic                         out_valid;
  logic                         out_ready;
  logic [DATA_WIDTH*size-1:0]   out_data;
  logic [CH_W-1:0]              out_ch;
  logic                         cfg_we;
  logic [CH_W-1:0]              cfg_addr;
  logic [DATA_WIDTH-1:0]        cfg_gamma;
  logic [DATA_WIDTH-1:0]        cfg_beta;

  modport master (
    output in_valid, in_data, frame_start, out_ready,
    output cfg_we, cfg_addr, cfg_gamma, cfg_beta,
    input  in_ready, out_valid, out_data, out_ch
  );

  modport slave (
    input  in_valid, in_data, frame_start, out_ready,
    input  cfg_we, cfg_addr, cfg_gamma, cfg_beta,
    output in_ready, out_valid, out_data, out_ch
  );
endinterface

// File: rtl/bn_affine_act.sv
// Per-channel affine (y = gamma*x + beta) plus optional LeakyReLU on half-precision lanes, 3-stage stall pipeline.
// Define BN_LEAKY_EN to enable the LeakyReLU; otherwise the activation is identity.
module bn_affine_act #(
  parameter int          DATA_WIDTH   = 16,
  parameter int          size         = 4,
  parameter int          CHANNELS     = 32,
  parameter int          BEATS_PER_CH = 8,
  parameter logic [15:0] LEAKY_SLOPE  = 16'h2E66
) (
  input  logic            clk,
  input  logic            reset,
  bn_affine_act_if.slave  bus
);
  localparam int CH_W   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int BEAT_W = (BEATS_PER_CH > 1) ? $clog2(BEATS_PER_CH) : 1;
  localparam int VEC_W  = DATA_WIDTH * size;

  if (DATA_WIDTH != 16) begin : g_bad_width
    $error("bn_affine_act supports only IEEE-754 half lanes");
  end
  // A negative slope would flip the sign of the negative branch, which the sign test assumes cannot happen.
  if (LEAKY_SLOPE[15]) begin : g_bad_slope
    $error("LEAKY_SLOPE must be a positive half value");
  end

  // Round-to-nearest-even and pack; subnormal results flush to signed zero.
  function automatic logic [15:0] fp_round(input logic s, input int e, input logic [10:0] sig,
                                           input logic rb, input logic sb);
    logic [11:0] r;
    int          ee;
    r  = {1'b0, sig} + {11'h0, rb & (sb | sig[0])};
    ee = e;
    if (r[11]) begin
      r  = r >> 1;
      ee = ee + 1;
    end
    if (ee >= 31) return {s, 5'h1f, 10'h0};
    if (ee <= 0)  return {s, 15'h0};
    return {s, 5'(ee), r[9:0]};
  endfunction

  function automatic logic [15:0] fp_mul(input logic [15:0] a, input logic [15:0] b);
    logic        s;
    logic [4:0]  ea, eb;
    logic [21:0] prod;
    int          e;
    s  = a[15] ^ b[15];
    ea = a[14:10];
    eb = b[14:10];
    if (ea == 5'h1f || eb == 5'h1f) begin
      if ((ea == 5'h1f && a[9:0] != 10'h0) || (eb == 5'h1f && b[9:0] != 10'h0) ||
          ea == 5'h0 || eb == 5'h0)
        return 16'h7E00;
      return {s, 5'h1f, 10'h0};
    end
    if (ea == 5'h0 || eb == 5'h0) return {s, 15'h0};
    prod = 22'({1'b1, a[9:0]}) * 22'({1'b1, b[9:0]});
    e    = int'(ea) + int'(eb) - 15;
    if (prod[21])
      return fp_round(s, e + 1, prod[21:11], prod[10], |prod[9:0]);
    return fp_round(s, e, prod[20:10], prod[9], |prod[8:0]);
  endfunction

  function automatic logic [15:0] fp_add(input logic [15:0] a, input logic [15:0] b);
    logic [15:0] big, sml;
    logic [13:0] mb, ms;
    logic [14:0] acc;
    logic        st;
    int          e, d;
    if (a[14:10] == 5'h0 && b[14:10] == 5'h0) return {a[15] & b[15], 15'h0};
    if (a[14:10] == 5'h0) return b;
    if (b[14:10] == 5'h0) return a;
    if (a[14:0] >= b[14:0]) begin
      big = a;
      sml = b;
    end else begin
      big = b;
      sml = a;
    end
    if (big[14:10] == 5'h1f) begin
      if (big[9:0] != 10'h0) return 16'h7E00;
      if (sml[14:10] == 5'h1f && sml[15] != big[15]) return 16'h7E00;
      return big;
    end
    // Three guard positions below the hidden bit; shifted-out bits fold into a sticky LSB.
    mb = {1'b1, big[9:0], 3'b000};
    ms = {1'b1, sml[9:0], 3'b000};
    e  = int'(big[14:10]);
    d  = int'(big[14:10]) - int'(sml[14:10]);
    st = 1'b0;
    for (int i = 0; i < 14; i++) begin
      if (i < d) begin
        st = st | ms[0];
        ms = ms >> 1;
      end
    end
    ms[0] = ms[0] | st;
    if (big[15] == sml[15]) begin
      acc = {1'b0, mb} + {1'b0, ms};
      if (acc[14]) begin
        acc = {1'b0, acc[14:2], acc[1] | acc[0]};
        e   = e + 1;
      end
    end else begin
      acc = {1'b0, mb - ms};
      if (acc == 15'h0) return 16'h0000;
      for (int i = 0; i < 13; i++) begin
        if (!acc[13]) begin
          acc = acc << 1;
          e   = e - 1;
        end
      end
    end
    return fp_round(big[15], e, acc[13:3], acc[2], |acc[1:0]);
  endfunction

  logic                  w_adv;
  logic                  w_acc;
  logic [BEAT_W-1:0]     w_beat_cur;
  logic [CH_W-1:0]       w_ch_cur;
  logic [BEAT_W-1:0]     r_beat_cnt;
  logic [CH_W-1:0]       r_ch_cnt;
  logic [DATA_WIDTH-1:0] r_gamma [CHANNELS];
  logic [DATA_WIDTH-1:0] r_beta  [CHANNELS];

  logic                  r_vld_p1, r_vld_p2, r_vld_p3;
  logic [VEC_W-1:0]      r_x_p1;
  logic [DATA_WIDTH-1:0] r_g_p1, r_b_p1, r_b_p2;
  logic [CH_W-1:0]       r_ch_p1, r_ch_p2, r_ch_p3;
  logic [VEC_W-1:0]      r_p_p2;
  logic [VEC_W-1:0]      r_y_p3;
  logic [VEC_W-1:0]      w_prod, w_sum, w_act;

  // The whole pipeline stalls together when the output is held by the consumer.
  assign w_adv         = bus.out_ready || !r_vld_p3;
  assign bus.in_ready  = w_adv && reset;
  assign w_acc         = bus.in_valid && bus.in_ready;
  assign w_beat_cur    = bus.frame_start ? '0 : r_beat_cnt;
  assign w_ch_cur      = bus.frame_start ? '0 : r_ch_cnt;

  assign bus.out_valid = r_vld_p3;
  assign bus.out_data  = r_y_p3;
  assign bus.out_ch    = r_ch_p3;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_beat_cnt <= '0;
      r_ch_cnt   <= '0;
    end else if (w_acc) begin
      if (w_beat_cur == BEAT_W'(BEATS_PER_CH - 1)) begin
        r_beat_cnt <= '0;
        r_ch_cnt   <= (w_ch_cur == CH_W'(CHANNELS - 1)) ? '0 : w_ch_cur + CH_W'(1);
      end else begin
        r_beat_cnt <= w_beat_cur + BEAT_W'(1);
        r_ch_cnt   <= w_ch_cur;
      end
    end
  end

  // Coefficient file: a same-edge write is not seen by the S1 read (non-blocking old value).
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int c = 0; c < CHANNELS; c++) begin
        r_gamma[c] <= DATA_WIDTH'(16'h3C00);
        r_beta[c]  <= '0;
      end
    end else if (bus.cfg_we) begin
      r_gamma[bus.cfg_addr] <= bus.cfg_gamma;
      r_beta[bus.cfg_addr]  <= bus.cfg_beta;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_vld_p1 <= 1'b0;
      r_vld_p2 <= 1'b0;
      r_vld_p3 <= 1'b0;
    end else if (w_adv) begin
      r_vld_p1 <= bus.in_valid;
      r_vld_p2 <= r_vld_p1;
      r_vld_p3 <= r_vld_p2;
    end
  end

  // S1: capture lanes and the channel's coefficients
  always_ff @(posedge clk) begin
    if (w_adv) begin
      r_x_p1  <= bus.in_data;
      r_ch_p1 <= w_ch_cur;
      r_g_p1  <= r_gamma[w_ch_cur];
      r_b_p1  <= r_beta[w_ch_cur];
    end
  end

  for (genvar i = 0; i < size; i++) begin : g_lane
    assign w_prod[i*DATA_WIDTH +: DATA_WIDTH] = fp_mul(r_g_p1, r_x_p1[i*DATA_WIDTH +: DATA_WIDTH]);
    assign w_sum[i*DATA_WIDTH +: DATA_WIDTH]  = fp_add(r_p_p2[i*DATA_WIDTH +: DATA_WIDTH], r_b_p2);
`ifdef BN_LEAKY_EN
    assign w_act[i*DATA_WIDTH +: DATA_WIDTH]  = w_sum[i*DATA_WIDTH + DATA_WIDTH - 1] ?
                                                fp_mul(w_sum[i*DATA_WIDTH +: DATA_WIDTH], LEAKY_SLOPE) :
                                                w_sum[i*DATA_WIDTH +: DATA_WIDTH];
`else
    assign w_act[i*DATA_WIDTH +: DATA_WIDTH]  = w_sum[i*DATA_WIDTH +: DATA_WIDTH];
`endif
  end

  // S2: gamma * x per lane
  always_ff @(posedge clk) begin
    if (w_adv) begin
      r_p_p2  <= w_prod;
      r_b_p2  <= r_b_p1;
      r_ch_p2 <= r_ch_p1;
    end
  end

  // S3: activation of p + beta drives the output
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_y_p3  <= '0;
      r_ch_p3 <= '0;
    end else if (w_adv) begin
      r_y_p3  <= w_act;
      r_ch_p3 <= r_ch_p2;
    end
  end
endmodule

// File: tb/tb_bn_affine_act.sv
// Directed bench for bn_affine_act: latency, affine/activation values, channel sequencing,
// back-pressure, coefficient write hazard, frame_start and mid-stream reset.
module tb_bn_affine_act;
  localparam int W   = 16;
  localparam int N   = 4;
  localparam int CH  = 32;
  localparam int BPC = 8;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  bn_affine_act_if #(.DATA_WIDTH(W), .size(N), .CHANNELS(CH)) bus ();

  bn_affine_act #(.DATA_WIDTH(W), .size(N), .CHANNELS(CH), .BEATS_PER_CH(BPC),
                  .LEAKY_SLOPE(16'h2E66)) dut (.clk(clk), .reset(reset), .bus(bus));

  typedef struct packed {
    logic [4:0]  ch;
    logic [63:0] d;
  } exp_t;

  int          checks   = 0;
  int          failures = 0;
  exp_t        q[$];
  logic [15:0] g_model [CH];
  int          m_beat, m_ch;
  bit          held;
  logic [63:0] held_d;
  logic [4:0]  held_ch;

  function automatic logic [63:0] rep(input logic [15:0] v);
    return {v, v, v, v};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    held   = 1'b0;
    m_beat = 0;
    m_ch   = 0;
    for (int c = 0; c < CH; c++) g_model[c] = 16'h3C00;
  endtask

  // One clock: drive, check the output being consumed/held, predict the accepted beat.
  // use_g expects lanes = gamma[ch] (valid for x = 1.0, beta = 0).
  task automatic step(input logic v, input logic [63:0] x, input logic fs, input logic ordy,
                      input logic use_g, input logic [63:0] exp_d, output logic acc);
    exp_t e;
    int   ch_use, beat_cur;
    bus.in_valid    = v;
    bus.in_data     = x;
    bus.frame_start = fs;
    bus.out_ready   = ordy;
    #1;
    if (held) begin
      chk("hold_valid", {63'h0, bus.out_valid}, 64'h1);
      chk("hold_data", bus.out_data, held_d);
      chk("hold_ch", {59'h0, bus.out_ch}, {59'h0, held_ch});
    end
    if (bus.out_valid && ordy) begin
      if (q.size() == 0) begin
        chk("unexpected_out", {63'h0, bus.out_valid}, 64'h0);
      end else begin
        e = q.pop_front();
        chk("out_data", bus.out_data, e.d);
        chk("out_ch", {59'h0, bus.out_ch}, {59'h0, e.ch});
      end
    end
    held    = bus.out_valid && !ordy;
    held_d  = bus.out_data;
    held_ch = bus.out_ch;
    acc     = v && bus.in_ready;
    if (acc) begin
      ch_use   = fs ? 0 : m_ch;
      beat_cur = fs ? 0 : m_beat;
      e.ch     = 5'(ch_use);
      e.d      = use_g ? rep(g_model[ch_use]) : exp_d;
      q.push_back(e);
      if (beat_cur == BPC - 1) begin
        m_beat = 0;
        m_ch   = (ch_use + 1) % CH;
      end else begin
        m_beat = beat_cur + 1;
        m_ch   = ch_use;
      end
    end
    if (bus.cfg_we) g_model[bus.cfg_addr] = bus.cfg_gamma;
    @(posedge clk);
    #1;
    bus.cfg_we = 1'b0;
  endtask

  task automatic cfg_step(input logic [4:0] a, input logic [15:0] g, input logic [15:0] b);
    logic acc;
    bus.cfg_we    = 1'b1;
    bus.cfg_addr  = a;
    bus.cfg_gamma = g;
    bus.cfg_beta  = b;
    step(1'b0, 64'h0, 1'b0, 1'b1, 1'b0, 64'h0, acc);
  endtask

  task automatic drain();
    logic acc;
    for (int i = 0; i < 20 && q.size() > 0; i++)
      step(1'b0, 64'h0, 1'b0, 1'b1, 1'b0, 64'h0, acc);
    chk("drain_left", 64'(q.size()), 64'h0);
    chk("drain_idle", {63'h0, bus.out_valid}, 64'h0);
  endtask

  task automatic do_reset();
    reset        = 1'b0;
    bus.in_valid = 1'b0;
    bus.cfg_we   = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    model_reset();
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        acc;
    logic [63:0] vx;
    logic [15:0] neg_exp;
    int          k, guard;

`ifdef BN_LEAKY_EN
    neg_exp = 16'hAE66;
`else
    neg_exp = 16'hBC00;
`endif
    reset           = 1'b0;
    bus.in_valid    = 1'b0;
    bus.in_data     = '0;
    bus.frame_start = 1'b0;
    bus.out_ready   = 1'b1;
    bus.cfg_we      = 1'b0;
    bus.cfg_addr    = '0;
    bus.cfg_gamma   = '0;
    bus.cfg_beta    = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", {63'h0, bus.out_valid}, 64'h0);
    chk("rst_out_data", bus.out_data, 64'h0);
    chk("rst_out_ch", {59'h0, bus.out_ch}, 64'h0);
    chk("rst_in_ready", {63'h0, bus.in_ready}, 64'h0);
    reset = 1'b1;

    // Latency: default coefficients, 0.5 in -> 0.5 out three cycles later
    bus.in_valid = 1'b1;
    bus.in_data  = rep(16'h3800);
    #1;
    chk("lat_in_ready", {63'h0, bus.in_ready}, 64'h1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    chk("lat_c1", {63'h0, bus.out_valid}, 64'h0);
    @(posedge clk);
    #1;
    chk("lat_c2", {63'h0, bus.out_valid}, 64'h0);
    @(posedge clk);
    #1;
    chk("lat_c3_valid", {63'h0, bus.out_valid}, 64'h1);
    chk("lat_c3_data", bus.out_data, rep(16'h3800));
    chk("lat_c3_ch", {59'h0, bus.out_ch}, 64'h0);
    @(posedge clk);
    #1;
    chk("lat_bubble", {63'h0, bus.out_valid}, 64'h0);
    m_beat = 1;

    // gamma=2, beta=1 on ch0
    cfg_step(5'd0, 16'h4000, 16'h3C00);
    step(1'b1, rep(16'h3800), 1'b1, 1'b1, 1'b0, rep(16'h4000), acc);
    step(1'b1, rep(16'hBC00), 1'b1, 1'b1, 1'b0, rep(neg_exp), acc);
    step(1'b1, {16'h3800, 16'hBC00, 16'h0000, 16'h3800}, 1'b1, 1'b1, 1'b0,
         {16'h4000, neg_exp, 16'h3C00, 16'h4000}, acc);
    drain();

    // Full frame plus one beat with distinct gamma per channel
    do_reset();
    for (int c = 0; c < CH; c++) cfg_step(5'(c), 16'h3C00 + 16'(c), 16'h0000);
    for (int b = 0; b < CH * BPC + 1; b++)
      step(1'b1, rep(16'h3C00), (b == 0), 1'b1, 1'b1, 64'h0, acc);
    drain();

    // Random back-pressure with distinct lanes; identity coefficients
    do_reset();
    k     = 0;
    guard = 0;
    while (k < 60 && guard < 1000) begin
      vx = {16'h3C00 + 16'(k), 16'h4000 + 16'(k), 16'h3800 + 16'(k), 16'h4400 + 16'(k)};
      step(1'b1, vx, (k == 0), 1'($urandom_range(0, 1)), 1'b0, vx, acc);
      if (acc) k++;
      guard++;
    end
    chk("stall_all_sent", 64'(k), 64'd60);
    drain();

    // Coefficient write on the same edge a ch0 beat is captured
    do_reset();
    bus.cfg_we    = 1'b1;
    bus.cfg_addr  = 5'd0;
    bus.cfg_gamma = 16'h4000;
    bus.cfg_beta  = 16'h0000;
    step(1'b1, rep(16'h3800), 1'b1, 1'b1, 1'b0, rep(16'h3800), acc);
    step(1'b1, rep(16'h3800), 1'b1, 1'b1, 1'b0, rep(16'h3C00), acc);
    drain();

    // frame_start at ch5 beat3
    do_reset();
    for (int b = 0; b < 5 * BPC + 3; b++)
      step(1'b1, rep(16'h3C00), 1'b0, 1'b1, 1'b1, 64'h0, acc);
    chk("fs_model_ch", 64'(m_ch), 64'd5);
    step(1'b1, rep(16'h3C00), 1'b1, 1'b1, 1'b1, 64'h0, acc);
    for (int b = 0; b < 9; b++)
      step(1'b1, rep(16'h3C00), 1'b0, 1'b1, 1'b1, 64'h0, acc);
    drain();

    // Reset with three beats in flight
    cfg_step(5'd0, 16'h4000, 16'h0000);
    for (int b = 0; b < 3; b++)
      step(1'b1, rep(16'h3800), (b == 0), 1'b1, 1'b0, rep(16'h3C00), acc);
    chk("pre_rst_valid", {63'h0, bus.out_valid}, 64'h1);
    reset        = 1'b0;
    bus.in_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("mid_rst_valid", {63'h0, bus.out_valid}, 64'h0);
    chk("mid_rst_in_ready", {63'h0, bus.in_ready}, 64'h0);
    reset = 1'b1;
    model_reset();
    step(1'b1, rep(16'h3800), 1'b1, 1'b1, 1'b0, rep(16'h3800), acc);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
